// File: rtl/score_arbiter.sv
// Two-player scoreboard arbiter: synchronises and optionally debounces four
// push-button requests, latches each press as pending, then services home and
// guest in round-robin order with saturating +1/-1 updates.
// Optional input filter: define SCORE_ARB_DEBOUNCE_EN to require DEB_CYCLES
// consecutive high samples before a press is accepted.
module score_arbiter #(
    parameter int BW         = 7,
    parameter int MAX_VAL    = 99,
    parameter int DEB_CYCLES = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    req_up_i,
    input  logic [1:0]    req_down_i,
    output logic [BW-1:0] score0_o,
    output logic [BW-1:0] score1_o,
    output logic [1:0]    grant_o,
    output logic          busy_o,
    output logic          upd_o,
    output logic          sat_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        UPDATE
    } state_t;

    localparam logic [BW-1:0] MAXV = BW'(MAX_VAL);

    // Request vector layout: [0] up0, [1] up1, [2] down0, [3] down1.
    localparam logic [3:0] REQ0_MASK = 4'b0101;
    localparam logic [3:0] REQ1_MASK = 4'b1010;

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] deb;
    logic [3:0] deb_prev_q;
    logic [3:0] rise;
    logic [3:0] pend_q, pend_d, clr;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    sel;
    logic [1:0]    req_any;
    logic          ptr_q, ptr_d;
    logic [BW-1:0] score0_q, score0_d, score1_q, score1_d;
    logic [BW-1:0] cur, nxt;
    logic          up, dn;
    logic          upd_q, upd_d, sat_q, sat_d;

    // Two-flop synchroniser for all four button inputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {req_down_i, req_up_i};
            sync2_q <= sync1_q;
        end
    end

`ifdef SCORE_ARB_DEBOUNCE_EN
    localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);

    logic [3:0] cnt_q [4];
    logic [3:0] cnt_d [4];
    logic [3:0] deb_q, deb_d;

    // Count consecutive high samples; level rises on the DEB_CYCLES-th, drops on any low.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            deb_d[i] = 1'b0;
            if (sync2_q[i]) begin
                cnt_d[i] = (cnt_q[i] == DEB_MAX) ? cnt_q[i] : cnt_q[i] + 4'd1;
                deb_d[i] = (cnt_q[i] >= DEB_MAX - 4'd1);
            end
        end
    end

    // Debounce counter and level registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
            deb_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            deb_q <= deb_d;
        end
    end

    assign deb = deb_q;
`else
    assign deb = sync2_q;
`endif

    assign rise    = deb & ~deb_prev_q;
    assign req_any = {pend_q[1] | pend_q[3], pend_q[0] | pend_q[2]};
    // On conflict ptr_q names the favoured requester.
    assign sel     = (&req_any) ? (ptr_q ? 2'b10 : 2'b01) : req_any;

    // A new press is kept even if its requester is cleared on the same edge.
    assign pend_d = (pend_q & ~clr) | rise;

    // Arbitration FSM next-state, score arithmetic and pulse generation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        clr      = '0;
        score0_d = score0_q;
        score1_d = score1_q;
        upd_d    = 1'b0;
        sat_d    = 1'b0;
        up       = gnt_q[1] ? pend_q[1] : pend_q[0];
        dn       = gnt_q[1] ? pend_q[3] : pend_q[2];
        cur      = gnt_q[1] ? score1_q : score0_q;
        nxt      = cur;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) state_d = ARB;
            end
            ARB: begin
                gnt_d   = sel;
                state_d = (|sel) ? UPDATE : IDLE;
            end
            UPDATE: begin
                if (up && !dn) begin
                    if (cur == MAXV) sat_d = 1'b1;
                    else             nxt   = cur + BW'(1);
                end else if (dn && !up) begin
                    if (cur == '0) sat_d = 1'b1;
                    else           nxt   = cur - BW'(1);
                end
                if (gnt_q[1]) score1_d = nxt;
                else          score0_d = nxt;
                clr     = gnt_q[1] ? REQ1_MASK : REQ0_MASK;
                // Favour the requester not just served (a toggle whenever both contend).
                ptr_d   = gnt_q[0];
                upd_d   = 1'b1;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending, score and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            deb_prev_q <= '0;
            pend_q     <= '0;
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= 1'b0;
            score0_q   <= '0;
            score1_q   <= '0;
            upd_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            pend_q     <= pend_d;
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            score0_q   <= score0_d;
            score1_q   <= score1_d;
            upd_q      <= upd_d;
            sat_q      <= sat_d;
        end
    end

    assign score0_o = score0_q;
    assign score1_o = score1_q;
    assign grant_o  = (state_q == ARB) ? sel : gnt_q;
    assign busy_o   = (state_q != IDLE);
    assign upd_o    = upd_q;
    assign sat_o    = sat_q;

endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter with a scoreboard of expected updates.
module tb_score_arbiter;

    localparam int DEB = 4;
`ifdef SCORE_ARB_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 4;
`else
    localparam int LAT = 2 + 4;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] req_up_i = '0;
    logic [1:0] req_down_i = '0;
    logic [6:0] score0_o, score1_o;
    logic [1:0] grant_o;
    logic       busy_o, upd_o, sat_o;

    score_arbiter #(.BW(7), .MAX_VAL(99), .DEB_CYCLES(DEB)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_up_i(req_up_i), .req_down_i(req_down_i),
        .score0_o(score0_o), .score1_o(score1_o), .grant_o(grant_o),
        .busy_o(busy_o), .upd_o(upd_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s0;
        int s1;
        int sat;
        int gnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int failures = 0;
    int upd_count = 0;
    int sat_count = 0;
    int m0 = 0;
    int m1 = 0;
    logic [1:0] last_grant = '0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int gnt, input int sat);
        sb.push_back('{s0: m0, s1: m1, sat: sat, gnt: gnt});
    endtask

    task automatic model_up(input int idx);
        if (idx == 0) begin
            if (m0 == 99) push(1, 1); else begin m0++; push(1, 0); end
        end else begin
            if (m1 == 99) push(2, 1); else begin m1++; push(2, 0); end
        end
    endtask

    task automatic model_dn(input int idx);
        if (idx == 0) begin
            if (m0 == 0) push(1, 1); else begin m0--; push(1, 0); end
        end else begin
            if (m1 == 0) push(2, 1); else begin m1--; push(2, 0); end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        req_up_i = '0;
        req_down_i = '0;
        repeat (3) tick();
        chk("rst_score0", score0_o, 0);
        chk("rst_score1", score1_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_upd", upd_o, 0);
        chk("rst_sat", sat_o, 0);
        rst_i = 1'b1;
        m0 = 0;
        m1 = 0;
    endtask

    task automatic press(input logic [1:0] up, input logic [1:0] dn);
        req_up_i = up;
        req_down_i = dn;
        repeat (6) tick();
        req_up_i = '0;
        req_down_i = '0;
        repeat (10) tick();
    endtask

    // Output monitor: every upd_o pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (busy_o && grant_o != 2'b00) last_grant = grant_o;
        if (upd_o) begin
            upd_count++;
            if (sat_o) sat_count++;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_score0", score0_o, e.s0);
                chk("sb_score1", score1_o, e.s1);
                chk("sb_sat", sat_o, e.sat);
                chk("sb_grant", last_grant, e.gnt);
            end
        end
    end

    initial begin
        // Single press held 20 cycles: exact latency and one update.
        do_reset();
        base = upd_count;
        model_up(0);
        req_up_i = 2'b01;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) chk("lat_before", score0_o, 0);
            if (k == LAT) begin
                chk("lat_score0", score0_o, 1);
                chk("lat_upd", upd_o, 1);
            end
        end
        repeat (20 - LAT) tick();
        req_up_i = '0;
        repeat (10) tick();
        chk("held_one_upd", upd_count - base, 1);

        // Simultaneous home/guest: home first, guest next round.
        do_reset();
        model_up(0);
        model_up(1);
        press(2'b11, 2'b00);
        chk("both_score0", score0_o, 1);
        chk("both_score1", score1_o, 1);

        // 101 guest presses saturate at 99.
        do_reset();
        base = sat_count;
        for (int n = 0; n < 101; n++) begin
            model_up(1);
            press(2'b10, 2'b00);
        end
        chk("max_score1", score1_o, 99);
        chk("max_sat_pulses", sat_count - base, 2);

        // Down at zero saturates for each requester.
        do_reset();
        base = sat_count;
        model_dn(1);
        press(2'b00, 2'b10);
        model_dn(0);
        press(2'b00, 2'b01);
        chk("zero_score0", score0_o, 0);
        chk("zero_score1", score1_o, 0);
        chk("zero_sat_pulses", sat_count - base, 2);

        // Up and down together at 5: unchanged, still one update, pending cleared.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            model_up(0);
            press(2'b01, 2'b00);
        end
        chk("pre_cancel_score0", score0_o, 5);
        base = upd_count;
        push(1, 0);
        press(2'b01, 2'b01);
        repeat (20) tick();
        chk("cancel_score0", score0_o, 5);
        chk("cancel_one_upd", upd_count - base, 1);
        chk("cancel_idle", busy_o, 0);

        // Three-cycle glitch.
        base = upd_count;
        req_up_i = 2'b01;
        repeat (3) tick();
        req_up_i = '0;
`ifdef SCORE_ARB_DEBOUNCE_EN
        repeat (15) tick();
        chk("glitch_score0", score0_o, 5);
        chk("glitch_no_upd", upd_count - base, 0);
`else
        model_up(0);
        repeat (2) tick();
        chk("glitch_before", score0_o, 5);
        tick();
        chk("glitch_score0", score0_o, 6);
        repeat (10) tick();
        chk("glitch_one_upd", upd_count - base, 1);
`endif

        // Button held through reset release counts once after full delay.
        rst_i = 1'b0;
        req_up_i = 2'b10;
        repeat (3) tick();
        chk("held_rst_score1", score1_o, 0);
        rst_i = 1'b1;
        m0 = 0;
        m1 = 0;
        model_up(1);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) chk("held_rst_before", score1_o, 0);
            if (k == LAT) chk("held_rst_after", score1_o, 1);
        end
        repeat (10) tick();
        req_up_i = '0;
        repeat (10) tick();

        // Reset during UPDATE aborts the write.
        do_reset();
        base = upd_count;
        req_up_i = 2'b01;
        repeat (LAT - 1) tick();
        chk("abort_busy_before", busy_o, 1);
        rst_i = 1'b0;
        tick();
        req_up_i = '0;
        rst_i = 1'b1;
        chk("abort_score0", score0_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_upd", upd_o, 0);
        repeat (20) tick();
        chk("abort_no_upd", upd_count - base, 0);
        chk("abort_score0_late", score0_o, 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
